// File: rtl/fp_mult_sequencer.sv
// fp_mult_sequencer: iterative IEEE-754 multiplier (binary32/binary64), one operation in flight; FP_MULT_SEQUENCER_STICKY_EN adds sticky flags.
// Latency: special operands 2 cycles, normal operands MW+3 cycles; result held in DONE until out_ready, in_ready only in IDLE.
module fp_mult_sequencer #(
  parameter int IS_DOUBLE = 0,
  parameter int WIDTH     = (IS_DOUBLE == 1) ? 64 : 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero,
  output logic             is_invalid
`ifdef FP_MULT_SEQUENCER_STICKY_EN
  ,
  input  logic             flags_clr,
  output logic [3:0]       sticky_flags
`endif
);
  localparam int EW = (IS_DOUBLE == 1) ? 11 : 8;
  localparam int FW = WIDTH - EW - 1;
  localparam int MW = FW + 1;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(MW);
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, MULT, NORM, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]     a_q, b_q;
  logic [CW-1:0]        cnt;
  logic [MW-1:0]        mcand;
  logic [2*MW-1:0]      prod;
  logic                 sign_q;
  logic signed [XW-1:0] exp_q;
  logic [3:0]           flags_q;

  logic [EW-1:0] e1, e2;
  logic [FW-1:0] f1, f2;
  logic          z1, z2, inf1, inf2, nan1, nan2, sgn, special;

  // Exponent field of zero covers both true zeros and flushed denormals.
  assign e1      = a_q[WIDTH-2 -: EW];
  assign e2      = b_q[WIDTH-2 -: EW];
  assign f1      = a_q[FW-1:0];
  assign f2      = b_q[FW-1:0];
  assign z1      = (e1 == '0);
  assign z2      = (e2 == '0);
  assign inf1    = (&e1) && (f1 == '0);
  assign inf2    = (&e2) && (f2 == '0);
  assign nan1    = (&e1) && (f1 != '0);
  assign nan2    = (&e2) && (f2 != '0);
  assign sgn     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign special = nan1 | nan2 | inf1 | inf2 | z1 | z2;

  // Shift-add step: upper half accumulates, multiplier bits retire from the bottom.
  logic [MW:0] psum;
  assign psum = {1'b0, prod[2*MW-1:MW]} + (prod[0] ? {1'b0, mcand} : {(MW+1){1'b0}});

  logic                 hi, guard, sticky, rnd;
  logic [MW-1:0]        mant;
  logic [MW:0]          mant_r;
  logic [FW-1:0]        frac;
  logic signed [XW-1:0] exp_n;

  assign hi     = prod[2*MW-1];
  assign mant   = hi ? prod[2*MW-1:MW] : prod[2*MW-2:MW-1];
  assign guard  = hi ? prod[MW-1] : prod[MW-2];
  assign sticky = hi ? (|prod[MW-2:0]) : (|prod[MW-3:0]);
  assign rnd    = guard & (sticky | mant[0]);
  assign mant_r = {1'b0, mant} + {{MW{1'b0}}, rnd};
  assign frac   = mant_r[MW] ? mant_r[FW:1] : mant_r[FW-1:0];
  assign exp_n  = exp_q + $signed({{(XW-1){1'b0}}, hi}) + $signed({{(XW-1){1'b0}}, mant_r[MW]});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = CLASSIFY;
      end
      CLASSIFY: state_nxt = special ? DONE : MULT;
      MULT:     if (cnt == CW'(MW - 1)) state_nxt = NORM;
      NORM:     state_nxt = DONE;
      DONE: begin
        out_valid = !rst;
        if (out_ready) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      result  <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= op1;
          b_q <= op2;
        end
        CLASSIFY: begin
          sign_q <= sgn;
          exp_q  <= $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;
          mcand  <= {1'b1, f1};
          prod   <= {{MW{1'b0}}, 1'b1, f2};
          cnt    <= '0;
          if (nan1 || nan2) begin
            result  <= QNAN;
            flags_q <= 4'b0100;
          end else if ((z1 && inf2) || (inf1 && z2)) begin
            result  <= QNAN;
            flags_q <= 4'b1100;
          end else if (inf1 || inf2) begin
            result  <= {sgn, {EW{1'b1}}, {FW{1'b0}}};
            flags_q <= 4'b0010;
          end else if (z1 || z2) begin
            result  <= {sgn, {(WIDTH-1){1'b0}}};
            flags_q <= 4'b0001;
          end
        end
        MULT: begin
          prod <= {psum, prod[MW-1:1]};
          cnt  <= cnt + CW'(1);
        end
        NORM: begin
          if (exp_n >= EMAX) begin
            result  <= {sign_q, {EW{1'b1}}, {FW{1'b0}}};
            flags_q <= 4'b0010;
          end else if (exp_n[XW-1] || exp_n == '0) begin
            result  <= {sign_q, {(WIDTH-1){1'b0}}};
            flags_q <= 4'b0001;
          end else begin
            result  <= {sign_q, exp_n[EW-1:0], frac};
            flags_q <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign {is_invalid, is_nan, is_inf, is_zero} = flags_q;

`ifdef FP_MULT_SEQUENCER_STICKY_EN
  // A clear and a handshake in the same cycle keep the handshake's flags.
  always_ff @(posedge clk) begin
    if (rst) sticky_flags <= '0;
    else     sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) |
                             ((out_valid && out_ready) ? flags_q : 4'b0000);
  end
`endif
endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Bench for fp_mult_sequencer: single and double instances checked against an arithmetic reference model
// every cycle, plus directed vectors with hand-computed literals.
module tb_fp_mult_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv_s = 1'b0, ordy_s = 1'b0, ir_s, ov_s;
  logic [31:0] a_s = '0, b_s = '0, res_s;
  logic        nan_s, inf_s, zero_s, inv_s;
  logic        iv_d = 1'b0, ordy_d = 1'b0, ir_d, ov_d;
  logic [63:0] a_d = '0, b_d = '0, res_d;
  logic        nan_d, inf_d, zero_d, inv_d;
`ifdef FP_MULT_SEQUENCER_STICKY_EN
  logic        clr_s = 1'b0, clr_d = 1'b0;
  logic [3:0]  stk_s, stk_d;
  logic [3:0]  stk_m = 4'b0000;
`endif

  fp_mult_sequencer #(.IS_DOUBLE(0)) u_s (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .op1(a_s), .op2(b_s),
    .out_valid(ov_s), .out_ready(ordy_s), .result(res_s),
    .is_nan(nan_s), .is_inf(inf_s), .is_zero(zero_s), .is_invalid(inv_s)
`ifdef FP_MULT_SEQUENCER_STICKY_EN
    , .flags_clr(clr_s), .sticky_flags(stk_s)
`endif
  );

  fp_mult_sequencer #(.IS_DOUBLE(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(iv_d), .in_ready(ir_d), .op1(a_d), .op2(b_d),
    .out_valid(ov_d), .out_ready(ordy_d), .result(res_d),
    .is_nan(nan_d), .is_inf(inf_d), .is_zero(zero_d), .is_invalid(inv_d)
`ifdef FP_MULT_SEQUENCER_STICKY_EN
    , .flags_clr(clr_d), .sticky_flags(stk_d)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  bit          started = 1'b0;
  bit          pend [2];
  bit          seen [2];
  longint      t_acc [2];
  int          lat [2];
  logic [63:0] er [2];
  logic [3:0]  ef [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, round-to-nearest-even by remainder vs half-ulp.
  function automatic void fmodel(input logic [63:0] a, input logic [63:0] b, input bit dbl,
                                 output logic [63:0] r, output logic [3:0] fl, output int lt);
    int ew, fw, sh;
    logic [63:0] emask, fmask, f1, f2;
    longint e1, e2, e;
    bit s, z1, z2, i1, i2, n1, n2;
    logic [127:0] p, mant, rem, half;
    ew = dbl ? 11 : 8;
    fw = dbl ? 52 : 23;
    emask = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << fw) - 64'd1;
    e1 = longint'((a >> fw) & emask);
    e2 = longint'((b >> fw) & emask);
    f1 = a & fmask;
    f2 = b & fmask;
    s  = a[ew+fw] ^ b[ew+fw];
    z1 = (e1 == 0);
    z2 = (e2 == 0);
    i1 = (e1 == longint'(emask)) && (f1 == 0);
    i2 = (e2 == longint'(emask)) && (f2 == 0);
    n1 = (e1 == longint'(emask)) && (f1 != 0);
    n2 = (e2 == longint'(emask)) && (f2 != 0);
    lt = 2;
    r  = '0;
    if (n1 || n2) begin
      fl = 4'b0100; r = (emask << fw) | (64'd1 << (fw - 1));
    end else if ((z1 && i2) || (i1 && z2)) begin
      fl = 4'b1100; r = (emask << fw) | (64'd1 << (fw - 1));
    end else if (i1 || i2) begin
      fl = 4'b0010; r = (64'(s) << (ew + fw)) | (emask << fw);
    end else if (z1 || z2) begin
      fl = 4'b0001; r = 64'(s) << (ew + fw);
    end else begin
      lt = fw + 4;
      p  = 128'((64'd1 << fw) | f1) * 128'((64'd1 << fw) | f2);
      e  = e1 + e2 - longint'(emask >> 1);
      sh = fw;
      if (p[2*fw+1]) begin sh = fw + 1; e = e + 1; end
      mant = p >> sh;
      rem  = p - (mant << sh);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
      if (mant[fw+1]) begin mant = mant >> 1; e = e + 1; end
      if (e >= longint'(emask)) begin
        fl = 4'b0010; r = (64'(s) << (ew + fw)) | (emask << fw);
      end else if (e <= 0) begin
        fl = 4'b0001; r = 64'(s) << (ew + fw);
      end else begin
        fl = 4'b0000; r = (64'(s) << (ew + fw)) | (64'(e) << fw) | (mant[63:0] & fmask);
      end
    end
  endfunction

  task automatic mon(input int k, input logic iv, input logic ir, input logic ov, input logic ordy,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] res, input logic [3:0] fl);
    logic [63:0] r;
    logic [3:0]  f;
    int          lt;
    if (rst) begin
      checks++;
      if (ir !== 1'b0 || ov !== 1'b0) begin
        errors++; $display("FAIL reset_outputs[%0d] in_ready=%b out_valid=%b expected 0 0", k, ir, ov);
      end
      pend[k] = 1'b0;
      return;
    end
    if (pend[k]) begin
      checks++;
      if (ir !== 1'b0) begin errors++; $display("FAIL busy_in_ready[%0d] in_ready=%b expected 0", k, ir); end
      if (ov === 1'b1) begin
        if (!seen[k]) begin
          checks++;
          if (cyc - t_acc[k] != longint'(lat[k])) begin
            errors++; $display("FAIL latency[%0d] got %0d expected %0d", k, cyc - t_acc[k], lat[k]);
          end
        end
        checks++;
        if (res !== er[k] || fl !== ef[k]) begin
          errors++; $display("FAIL model_result[%0d] result=%h flags=%b expected %h %b", k, res, fl, er[k], ef[k]);
        end
        seen[k] = 1'b1;
        if (ordy === 1'b1) pend[k] = 1'b0;
      end else begin
        checks++;
        if (cyc - t_acc[k] >= longint'(lat[k])) begin
          errors++; $display("FAIL out_valid_late[%0d] out_valid=%b expected 1", k, ov);
          pend[k] = 1'b0;
        end
      end
    end else begin
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL spurious_valid[%0d] out_valid=%b expected 0", k, ov); end
    end
    if (iv && ir === 1'b1) begin
      fmodel(a, b, k == 1, r, f, lt);
      er[k] = r; ef[k] = f; lat[k] = lt;
      pend[k] = 1'b1; seen[k] = 1'b0; t_acc[k] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
`ifdef FP_MULT_SEQUENCER_STICKY_EN
      checks++;
      if (stk_s !== stk_m) begin errors++; $display("FAIL sticky_model sticky=%b expected %b", stk_s, stk_m); end
      if (rst) stk_m = 4'b0000;
      else     stk_m = (clr_s ? 4'b0000 : stk_m) | ((ov_s && ordy_s) ? ef[0] : 4'b0000);
`endif
      mon(0, iv_s, ir_s, ov_s, ordy_s, {32'b0, a_s}, {32'b0, b_s}, {32'b0, res_s}, {inv_s, nan_s, inf_s, zero_s});
      mon(1, iv_d, ir_d, ov_d, ordy_d, a_d, b_d, res_d, {inv_d, nan_d, inf_d, zero_d});
    end
  end

  function automatic logic get_ir(input int k);
    return (k == 1) ? ir_d : ir_s;
  endfunction
  function automatic logic get_ov(input int k);
    return (k == 1) ? ov_d : ov_s;
  endfunction
  function automatic logic [63:0] get_res(input int k);
    return (k == 1) ? res_d : {32'b0, res_s};
  endfunction
  function automatic logic [3:0] get_fl(input int k);
    return (k == 1) ? {inv_d, nan_d, inf_d, zero_d} : {inv_s, nan_s, inf_s, zero_s};
  endfunction

  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit,
                        input logic [3:0] lfl, input int hold, input string nm);
    int n;
    n = 0;
    while (get_ir(k) !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (k == 1) begin a_d = a; b_d = b; iv_d = 1'b1; end
    else begin a_s = a[31:0]; b_s = b[31:0]; iv_s = 1'b1; end
    @(posedge clk); #1;
    iv_s = 1'b0; iv_d = 1'b0;
    n = 0;
    while (get_ov(k) !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (get_ov(k) !== 1'b1) begin
      errors++; $display("FAIL %s_timeout out_valid=%b expected 1", nm, get_ov(k));
      return;
    end
    if (get_res(k) !== lit || get_fl(k) !== lfl) begin
      errors++; $display("FAIL %s result=%h flags=%b expected %h %b", nm, get_res(k), get_fl(k), lit, lfl);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (get_ov(k) !== 1'b1 || get_ir(k) !== 1'b0 || get_res(k) !== lit) begin
        errors++; $display("FAIL %s_hold out_valid=%b in_ready=%b result=%h expected 1 0 %h",
                           nm, get_ov(k), get_ir(k), get_res(k), lit);
      end
    end
    if (k == 1) ordy_d = 1'b1; else ordy_s = 1'b1;
    @(posedge clk); #1;
    ordy_s = 1'b0; ordy_d = 1'b0;
    checks++;
    if (get_ir(k) !== 1'b1) begin errors++; $display("FAIL %s_ready_after in_ready=%b expected 1", nm, get_ir(k)); end
  endtask

  initial begin
    bit saw_valid;
    rst = 1'b1;
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res_s !== 32'h0 || {inv_s, nan_s, inf_s, zero_s} !== 4'b0 || ir_s !== 1'b0 || ov_s !== 1'b0) begin
      errors++; $display("FAIL reset_state result=%h flags=%b in_ready=%b out_valid=%b expected 0 0 0 0",
                         res_s, {inv_s, nan_s, inf_s, zero_s}, ir_s, ov_s);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir_s !== 1'b1) begin errors++; $display("FAIL ready_after_reset in_ready=%b expected 1", ir_s); end

    run_op(0, 64'h40000000, 64'h40400000, 64'h40C00000, 4'b0000, 0, "two_times_three");
    run_op(0, 64'h00000000, 64'h7F800000, 64'h7FC00000, 4'b1100, 0, "zero_times_inf");
    run_op(0, 64'h7F800000, 64'h00000000, 64'h7FC00000, 4'b1100, 0, "inf_times_zero");
    run_op(0, 64'h7F000000, 64'h7F000000, 64'h7F800000, 4'b0010, 0, "overflow");
    run_op(0, 64'h00800000, 64'h00800000, 64'h00000000, 4'b0001, 0, "underflow");
`ifdef FP_MULT_SEQUENCER_STICKY_EN
    checks++;
    if (stk_s !== 4'b1111) begin errors++; $display("FAIL sticky_accum sticky=%b expected 1111", stk_s); end
    clr_s = 1'b1;
    @(posedge clk); #1;
    clr_s = 1'b0;
    checks++;
    if (stk_s !== 4'b0000) begin errors++; $display("FAIL sticky_clear sticky=%b expected 0000", stk_s); end
`endif
    run_op(0, 64'h40000000, 64'h40400000, 64'h40C00000, 4'b0000, 5, "backpressure");
    run_op(0, 64'h3FC00000, 64'h3FC00000, 64'h40100000, 4'b0000, 0, "one_half_sq");
    run_op(0, 64'h3F800001, 64'h3F800001, 64'h3F800002, 4'b0000, 0, "round_down");
    run_op(0, 64'h3FFFFFFF, 64'h3FFFFFFF, 64'h407FFFFE, 4'b0000, 0, "near_four");
    run_op(0, 64'h3FFFFFFF, 64'h3F800001, 64'h40000000, 4'b0000, 0, "round_carry");
    run_op(0, 64'hC0000000, 64'h40400000, 64'hC0C00000, 4'b0000, 0, "negative");
    run_op(0, 64'h7FC00001, 64'h3F800000, 64'h7FC00000, 4'b0100, 0, "nan_in");
    run_op(0, 64'h7F800000, 64'hFF800000, 64'hFF800000, 4'b0010, 0, "neg_inf");
    run_op(0, 64'h00000001, 64'h7F000000, 64'h00000000, 4'b0001, 0, "denorm_flush");
    run_op(0, 64'h80400000, 64'h3F800000, 64'h80000000, 4'b0001, 0, "neg_denorm");

    // Abort mid-multiply: reset lands while the bit counter sits at 10.
    a_s = 32'h3FC00000; b_s = 32'h40000000; iv_s = 1'b1;
    @(posedge clk); #1;
    iv_s = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ir_s !== 1'b1) begin errors++; $display("FAIL abort_ready in_ready=%b expected 1", ir_s); end
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov_s === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL abort_no_output out_valid seen=1 expected 0"); end
    run_op(0, 64'h3F800000, 64'hBF800000, 64'hBF800000, 4'b0000, 0, "after_abort");

    run_op(1, 64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000, 0, "dbl_two_times_three");
    run_op(1, 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1100, 2, "dbl_inf_times_zero");
    run_op(1, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'hBFF0000000000000, 4'b0000, 0, "dbl_neg_one");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish expected completion");
    $fatal(1, "watchdog");
  end
endmodule
